// File: rtl/mc_dp_pkg.sv
// Shared definitions for the mc_datapath multi-cycle accumulator machine:
// opcode and FSM state encodings plus instruction field geometry.
package mc_dp_pkg;

  localparam int OP_W     = 4;
  localparam int ADDR_LSB = 0;

  typedef enum logic [3:0] {
    OP_LDA  = 4'h0,
    OP_STA  = 4'h1,
    OP_MOV  = 4'h2,
    OP_ADD  = 4'h3,
    OP_SUB  = 4'h4,
    OP_AND  = 4'h5,
    OP_NOT  = 4'h6,
    OP_JMP  = 4'h7,
    OP_BZ   = 4'h8,
    OP_HALT = 4'hF
  } opcode_e;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6
  } state_e;

  function automatic logic is_legal(input opcode_e op);
    return (op inside {OP_LDA, OP_STA, OP_MOV, OP_ADD, OP_SUB, OP_AND,
                       OP_NOT, OP_JMP, OP_BZ, OP_HALT});
  endfunction

  // Opcodes whose write-back refreshes the zero flag.
  function automatic logic sets_zero(input opcode_e op);
    return (op inside {OP_LDA, OP_ADD, OP_SUB, OP_AND, OP_NOT});
  endfunction

endpackage

// File: rtl/mc_dp_alu.sv
// Combinational ALU for mc_datapath; modulo 2^DATA_W arithmetic, carry dropped.
// Non-ALU opcodes pass operand a through (used by MOV to forward r0).
module mc_dp_alu
  import mc_dp_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  opcode_e                   op,
  input  logic signed [DATA_W-1:0]  a,
  input  logic signed [DATA_W-1:0]  b,
  output logic signed [DATA_W-1:0]  result,
  output logic                      zero
);

  always_comb begin
    result = a;
    case (op)
      OP_ADD:  result = a + b;
      OP_SUB:  result = a - b;
      OP_AND:  result = a & b;
      OP_NOT:  result = ~a;
      default: result = a;
    endcase
    zero = (result == '0);
  end

endmodule

// File: rtl/mc_datapath.sv
// Multi-cycle accumulator datapath: FETCH/DECODE/EXEC/MEM/WB sequencer,
// NREG-entry register file (r0 = accumulator). Optional trace port: MC_DATAPATH_TRACE_EN.
module mc_datapath
  import mc_dp_pkg::*;
#(
  parameter  int DATA_W = 16,
  parameter  int NREG   = 8,
  localparam int PC_W   = DATA_W - OP_W,
  localparam int RSEL_W = $clog2(NREG)
) (
  input  logic              clk,
  input  logic              rst_n,
`ifdef MC_DATAPATH_TRACE_EN
  output logic              trace_valid,
  output logic [PC_W-1:0]   trace_pc,
  output logic [DATA_W-1:0] trace_ir,
  output logic [DATA_W-1:0] trace_wdata,
`endif
  input  logic              go,
  output logic              busy,
  output logic              done,
  output logic              illegal,
  output logic [PC_W-1:0]   imem_addr,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic [PC_W-1:0]   dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  output logic              dmem_we,
  output logic              dmem_re,
  input  logic [DATA_W-1:0] dmem_rdata,
  output logic [PC_W-1:0]   pc,
  output logic              zero,
  output logic [DATA_W-1:0] acc
);

  state_e              state_q, state_d;
  logic [PC_W-1:0]     pc_q, pc_inc;
  logic [DATA_W-1:0]   ir_p0, b_p1, res_p2, mdr_p3;
  logic                res_zero_p2;
  logic                zero_q, done_q, illegal_q;
  logic [DATA_W-1:0]   regs [NREG];

  opcode_e             op;
  logic [PC_W-1:0]     addr;
  logic [RSEL_W-1:0]   rsel;
  logic [DATA_W-1:0]   alu_res;
  logic                alu_zero;
  logic                wb_en;
  logic [RSEL_W-1:0]   wb_sel;
  logic [DATA_W-1:0]   wb_data;

  assign op     = opcode_e'(ir_p0[DATA_W-1 -: OP_W]);
  assign addr   = ir_p0[ADDR_LSB +: PC_W];
  assign rsel   = ir_p0[PC_W-1 -: RSEL_W];
  assign pc_inc = pc_q + PC_W'(1);

  // MOV into r0 is a no-op; everything else that reaches WB targets r0.
  assign wb_en   = (op != OP_MOV) || (rsel != '0);
  assign wb_sel  = (op == OP_MOV) ? rsel : '0;
  assign wb_data = (op == OP_LDA) ? mdr_p3 : res_p2;

  mc_dp_alu #(.DATA_W(DATA_W)) u_alu (
    .op     (op),
    .a      (regs[0]),
    .b      (b_p1),
    .result (alu_res),
    .zero   (alu_zero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (go) state_d = S_FETCH;
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        if (op == OP_JMP || op == OP_BZ) state_d = S_FETCH;
        else if (op == OP_HALT || !is_legal(op)) state_d = S_HALT;
        else state_d = S_EXEC;
      end
      S_EXEC: begin
        if (op == OP_LDA)      state_d = S_MEM;
        else if (op == OP_STA) state_d = S_FETCH;
        else                   state_d = S_WB;
      end
      S_MEM:    state_d = S_WB;
      S_WB:     state_d = S_FETCH;
      S_HALT:   if (go) state_d = S_FETCH;
      default:  state_d = S_IDLE;
    endcase
  end

  // Memory strobes decode straight from state so reset drops them at once.
  always_comb begin
    busy    = (state_q != S_IDLE) && (state_q != S_HALT);
    dmem_re = (state_q == S_EXEC) && (op == OP_LDA);
    dmem_we = (state_q == S_EXEC) && (op == OP_STA);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q        <= '0;
      ir_p0       <= '0;
      b_p1        <= '0;
      res_p2      <= '0;
      res_zero_p2 <= 1'b0;
      mdr_p3      <= '0;
      zero_q      <= 1'b1;
      done_q      <= 1'b0;
      illegal_q   <= 1'b0;
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else begin
      done_q <= (state_q == S_DECODE) && (state_d == S_HALT);
      case (state_q)
        // fetch
        S_FETCH: ir_p0 <= imem_rdata;
        // decode: operand latch, branches resolve here
        S_DECODE: begin
          b_p1 <= regs[rsel];
          if (op == OP_JMP)     pc_q <= addr;
          else if (op == OP_BZ) pc_q <= zero_q ? addr : pc_inc;
          if (!is_legal(op))    illegal_q <= 1'b1;
        end
        // execute
        S_EXEC: begin
          res_p2      <= alu_res;
          res_zero_p2 <= alu_zero;
          if (op == OP_STA) pc_q <= pc_inc;
        end
        // memory read return
        S_MEM: mdr_p3 <= dmem_rdata;
        // write-back
        S_WB: begin
          pc_q <= pc_inc;
          if (wb_en) regs[wb_sel] <= wb_data;
          if (sets_zero(op)) zero_q <= (op == OP_LDA) ? (mdr_p3 == '0) : res_zero_p2;
        end
        S_HALT: if (go) pc_q <= pc_inc;
        default: ;
      endcase
    end
  end

  assign imem_addr  = pc_q;
  assign dmem_addr  = addr;
  assign dmem_wdata = regs[0];
  assign pc         = pc_q;
  assign zero       = zero_q;
  assign acc        = regs[0];
  assign done       = done_q;
  assign illegal    = illegal_q;

`ifdef MC_DATAPATH_TRACE_EN
  always_comb begin
    trace_valid = (state_q == S_WB) ||
                  ((state_q == S_EXEC) && (op == OP_STA)) ||
                  ((state_q == S_DECODE) && (op inside {OP_JMP, OP_BZ, OP_HALT}));
    trace_pc    = pc_q;
    trace_ir    = ir_p0;
    trace_wdata = ((state_q == S_WB) && wb_en) ? wb_data : '0;
  end
`endif

endmodule

// File: tb/tb_mc_datapath.sv
// Bench for mc_datapath: table vectors, hand-written corner sequences and
// random straight-line programs checked against an instruction-level model.
module tb_mc_datapath;

  localparam int DW = 16;
  localparam int NR = 8;
  localparam int PW = 12;
  localparam int MSZ = 4096;

  logic          clk = 1'b0;
  logic          rst_n, go;
  logic          busy, done, illegal, dmem_we, dmem_re, zero;
  logic [PW-1:0] imem_addr, dmem_addr, pc;
  logic [DW-1:0] imem_rdata, dmem_wdata, dmem_rdata, acc;
`ifdef MC_DATAPATH_TRACE_EN
  logic          trace_valid;
  logic [PW-1:0] trace_pc;
  logic [DW-1:0] trace_ir, trace_wdata;
`endif

  logic [DW-1:0] imem [MSZ];
  logic [DW-1:0] dmem [MSZ];
  logic [DW-1:0] dm_init [MSZ];
  logic          dm_load = 1'b0, cnt_clr = 1'b0;
  int            we_cnt, both_cnt = 0;
  logic [DW-1:0] last_wdata;

  logic [DW-1:0] m_reg [NR];
  logic [DW-1:0] m_mem [MSZ];
  logic          m_zero, m_ill, m_halt;
  logic [PW-1:0] m_pc;

  int checks = 0, passes = 0;

  always #5 clk = ~clk;

  mc_datapath #(.DATA_W(DW), .NREG(NR)) dut (
    .clk(clk), .rst_n(rst_n),
`ifdef MC_DATAPATH_TRACE_EN
    .trace_valid(trace_valid), .trace_pc(trace_pc), .trace_ir(trace_ir), .trace_wdata(trace_wdata),
`endif
    .go(go), .busy(busy), .done(done), .illegal(illegal),
    .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_we(dmem_we), .dmem_re(dmem_re),
    .dmem_rdata(dmem_rdata), .pc(pc), .zero(zero), .acc(acc)
  );

  assign imem_rdata = imem[imem_addr];

  always @(posedge clk) begin
    if (dm_load) for (int i = 0; i < MSZ; i++) dmem[i] <= dm_init[i];
    else if (dmem_we) dmem[dmem_addr] <= dmem_wdata;
    if (dmem_re) dmem_rdata <= dmem[dmem_addr];
    if (cnt_clr) we_cnt <= 0;
    else if (dmem_we) begin
      we_cnt     <= we_cnt + 1;
      last_wdata <= dmem_wdata;
    end
    if (dmem_we && dmem_re) both_cnt <= both_cnt + 1;
  end

`ifdef MC_DATAPATH_TRACE_EN
  int            tr_cnt;
  logic [PW-1:0] tr_pc [4];
  logic [DW-1:0] tr_ir [4];
  always @(posedge clk) begin
    if (cnt_clr) tr_cnt <= 0;
    else if (trace_valid) begin
      if (tr_cnt < 4) begin
        tr_pc[tr_cnt[1:0]] <= trace_pc;
        tr_ir[tr_cnt[1:0]] <= trace_ir;
      end
      tr_cnt <= tr_cnt + 1;
    end
  end
`endif

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic clear_imem();
    for (int i = 0; i < MSZ; i++) imem[i] = 16'hF000;
  endtask

  task automatic clear_dinit();
    for (int i = 0; i < MSZ; i++) dm_init[i] = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; go = 1'b0; dm_load = 1'b1; cnt_clr = 1'b1;
    repeat (2) @(negedge clk);
    dm_load = 1'b0; cnt_clr = 1'b0; rst_n = 1'b1;
    for (int i = 0; i < NR; i++) m_reg[i] = '0;
    for (int i = 0; i < MSZ; i++) m_mem[i] = dm_init[i];
    m_zero = 1'b1; m_ill = 1'b0; m_halt = 1'b0; m_pc = '0;
  endtask

  // Instruction-level interpreter; cyc is the cycle (counting the go cycle as 0) at which done shows.
  task automatic model_run(output int cyc);
    logic [DW-1:0] w;
    logic [11:0]   a;
    int            rs;
    cyc = 1;
    if (m_halt) m_pc = m_pc + 12'd1;
    m_halt = 1'b0;
    for (int n = 0; n < 4000 && !m_halt; n++) begin
      w = imem[m_pc]; a = w[11:0]; rs = int'(w[11:9]);
      case (w[15:12])
        4'h0: begin m_reg[0] = m_mem[a]; m_zero = (m_reg[0] == 0); m_pc = m_pc + 1; cyc += 5; end
        4'h1: begin m_mem[a] = m_reg[0]; m_pc = m_pc + 1; cyc += 3; end
        4'h2: begin if (rs != 0) m_reg[rs] = m_reg[0]; m_pc = m_pc + 1; cyc += 4; end
        4'h3: begin m_reg[0] = m_reg[0] + m_reg[rs]; m_zero = (m_reg[0] == 0); m_pc = m_pc + 1; cyc += 4; end
        4'h4: begin m_reg[0] = m_reg[0] - m_reg[rs]; m_zero = (m_reg[0] == 0); m_pc = m_pc + 1; cyc += 4; end
        4'h5: begin m_reg[0] = m_reg[0] & m_reg[rs]; m_zero = (m_reg[0] == 0); m_pc = m_pc + 1; cyc += 4; end
        4'h6: begin m_reg[0] = ~m_reg[0]; m_zero = (m_reg[0] == 0); m_pc = m_pc + 1; cyc += 4; end
        4'h7: begin m_pc = a; cyc += 2; end
        4'h8: begin m_pc = m_zero ? a : m_pc + 12'd1; cyc += 2; end
        4'hF: begin m_halt = 1'b1; cyc += 2; end
        default: begin m_ill = 1'b1; m_halt = 1'b1; cyc += 2; end
      endcase
    end
  endtask

  task automatic run_dut(input bit spam, output int cyc);
    int cnt;
    @(negedge clk); go = 1'b1;
    @(negedge clk); go = 1'b0;
    cnt = 0;
    for (int k = 0; k < 1000; k++) begin
      @(posedge clk); #1;
      cnt++;
      go = spam && (cnt >= 2) && (cnt <= 4);
      if (done) break;
    end
    go = 1'b0;
    chk("done_arrived", done, 1'b1);
    cyc = cnt + 1;
  endtask

  task automatic post_checks(input string tag, input logic [DW-1:0] e_acc, input logic e_zero,
                             input logic e_ill, input logic [PW-1:0] e_pc, input int e_cyc, input int cyc);
    chk({tag, ".cycles"}, cyc, e_cyc);
    chk({tag, ".acc"}, acc, e_acc);
    chk({tag, ".zero"}, zero, e_zero);
    chk({tag, ".illegal"}, illegal, e_ill);
    chk({tag, ".pc"}, pc, e_pc);
    chk({tag, ".busy"}, busy, 1'b0);
    @(posedge clk); #1;
    chk({tag, ".done_pulse"}, done, 1'b0);
  endtask

  task automatic model_check(input string tag, input bit spam);
    int mc, dc, bad;
    model_run(mc);
    run_dut(spam, dc);
    post_checks(tag, m_reg[0], m_zero, m_ill, m_pc, mc, dc);
    bad = 0;
    for (int i = 0; i < MSZ; i++) if (dmem[i] !== m_mem[i]) bad++;
    chk({tag, ".dmem"}, bad, 0);
  endtask

  typedef struct {
    logic [DW-1:0] p0, p1, p2, p3;
    logic [DW-1:0] mval;
    logic [DW-1:0] acc;
    logic          zero;
    logic          ill;
    logic [PW-1:0] pc;
    int            cyc;
  } vec_t;
  vec_t vt [10];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    logic [3:0]  rop;
    logic [11:0] ra;
    int          n;

    //          program                              mval      acc       z     ill   pc       cycle of done
    vt[0] = '{16'h0005, 16'hF000, 16'hF000, 16'hF000, 16'h0003, 16'h0003, 1'b0, 1'b0, 12'h001, 8};
    vt[1] = '{16'h0005, 16'h6000, 16'hF000, 16'hF000, 16'hFFFF, 16'h0000, 1'b1, 1'b0, 12'h002, 12};
    vt[2] = '{16'h0005, 16'h2200, 16'h3200, 16'hF000, 16'h8001, 16'h0002, 1'b0, 1'b0, 12'h003, 16};
    vt[3] = '{16'h0005, 16'h4000, 16'h8007, 16'hF000, 16'h1234, 16'h0000, 1'b1, 1'b0, 12'h007, 14};
    vt[4] = '{16'h0005, 16'h5400, 16'hF000, 16'hF000, 16'h1234, 16'h0000, 1'b1, 1'b0, 12'h002, 12};
    vt[5] = '{16'h1006, 16'h7009, 16'hF000, 16'hF000, 16'h0000, 16'h0000, 1'b1, 1'b0, 12'h009, 8};
    vt[6] = '{16'h0005, 16'h2000, 16'hF000, 16'hF000, 16'h00F0, 16'h00F0, 1'b0, 1'b0, 12'h002, 12};
    vt[7] = '{16'h0005, 16'hA000, 16'hF000, 16'hF000, 16'h0007, 16'h0007, 1'b0, 1'b1, 12'h001, 8};
    vt[8] = '{16'h0005, 16'h800A, 16'hF000, 16'hF000, 16'h0001, 16'h0001, 1'b0, 1'b0, 12'h002, 10};
    vt[9] = '{16'h0005, 16'h6000, 16'h3000, 16'hF000, 16'h0000, 16'hFFFE, 1'b0, 1'b0, 12'h003, 16};

    go = 1'b0;
    clear_imem();
    clear_dinit();
    do_reset();
    #1;
    chk("rst.pc", pc, 12'h000);
    chk("rst.acc", acc, 16'h0000);
    chk("rst.zero", zero, 1'b1);
    chk("rst.busy", busy, 1'b0);
    chk("rst.done", done, 1'b0);
    chk("rst.illegal", illegal, 1'b0);
    chk("rst.we_re", {dmem_we, dmem_re}, 2'b00);

    for (int v = 0; v < 10; v++) begin
      clear_dinit();
      dm_init[5] = vt[v].mval;
      do_reset();
      clear_imem();
      imem[0] = vt[v].p0; imem[1] = vt[v].p1; imem[2] = vt[v].p2; imem[3] = vt[v].p3;
      run_dut(1'b0, cyc);
      post_checks($sformatf("vec%0d", v), vt[v].acc, vt[v].zero, vt[v].ill, vt[v].pc, vt[v].cyc, cyc);
    end

    // ADD wraps to zero, then BZ taken
    clear_dinit(); dm_init[5] = 16'h0001; dm_init[6] = 16'hFFFF;
    do_reset(); clear_imem();
    imem[0] = 16'h0005; imem[1] = 16'h2200; imem[2] = 16'h0006; imem[3] = 16'h3200; imem[4] = 16'h8020;
    model_check("addbz", 1'b0);
    chk("addbz.acc_k", acc, 16'h0000);
    chk("addbz.zero_k", zero, 1'b1);
    chk("addbz.pc_k", pc, 12'h020);

    // illegal opcode at 0x004, then restart from the following address
    clear_dinit(); dm_init[5] = 16'h0003;
    do_reset(); clear_imem();
    imem[0] = 16'h0005; imem[1] = 16'h2400; imem[2] = 16'h6000; imem[3] = 16'h3400; imem[4] = 16'hA000;
    model_check("ill", 1'b0);
    chk("ill.flag_k", illegal, 1'b1);
    chk("ill.pc_k", pc, 12'h004);
    chk("ill.acc_k", acc, 16'hFFFF);
    model_check("ill_restart", 1'b0);
    chk("ill_restart.sticky", illegal, 1'b1);
    chk("ill_restart.pc_k", pc, 12'h005);

    // pc wrap from 0xFFF, then a single store
    clear_dinit();
    do_reset(); clear_imem();
    imem[0] = 16'h8FFF; imem[12'hFFF] = 16'h6000; imem[1] = 16'h1010; imem[2] = 16'hF000;
    model_check("wrap", 1'b0);
    chk("wrap.we_cycles", we_cnt, 1);
    chk("wrap.wdata", last_wdata, 16'hFFFF);
    chk("wrap.mem", dmem[16], 16'hFFFF);
    chk("wrap.pc_k", pc, 12'h002);

    // reset during the store's EXEC cycle
    clear_dinit(); dm_init[16] = 16'h5A5A;
    do_reset(); clear_imem();
    imem[0] = 16'h1010;
    @(negedge clk); go = 1'b1;
    @(negedge clk); go = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      if (dmem_we) break;
    end
    chk("abort.we_seen", dmem_we, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("abort.we_drop", dmem_we, 1'b0);
    chk("abort.pc", pc, 12'h000);
    chk("abort.busy", busy, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("abort.idle", busy, 1'b0);
    chk("abort.mem", dmem[16], 16'h5A5A);
    chk("abort.we_cycles", we_cnt, 0);

    // go pulses while busy must not disturb the run
    clear_dinit(); dm_init[5] = 16'hFFFF;
    do_reset(); clear_imem();
    imem[0] = 16'h0005; imem[1] = 16'h6000; imem[2] = 16'hF000;
    model_check("gobusy", 1'b1);

`ifdef MC_DATAPATH_TRACE_EN
    clear_dinit(); dm_init[5] = 16'h0042;
    do_reset(); clear_imem();
    imem[0] = 16'h0005; imem[1] = 16'h6000; imem[2] = 16'hF000;
    model_check("trace", 1'b0);
    chk("trace.count", tr_cnt, 3);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("trace.pc%0d", i), tr_pc[i], 12'(i));
      chk($sformatf("trace.ir%0d", i), tr_ir[i], imem[i]);
    end
`endif

    for (int it = 0; it < 12; it++) begin
      clear_dinit();
      for (int i = 0; i < 16; i++) dm_init[i] = 16'($urandom);
      do_reset(); clear_imem();
      n = $urandom_range(6, 12);
      for (int p = 0; p < n; p++) begin
        rop = 4'($urandom_range(0, 8));
        if (rop <= 4'h1)      ra = 12'($urandom_range(0, 15));
        else if (rop >= 4'h7) ra = 12'($urandom_range(p + 1, n));
        else                  ra = 12'($urandom_range(0, 4095));
        imem[p] = {rop, ra};
      end
      model_check($sformatf("rnd%0d", it), 1'b0);
      if (it % 2 == 1) model_check($sformatf("rnd%0d_re", it), 1'b0);
    end

    chk("we_re_exclusive", both_cnt, 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
